eink_update_scheduler: RTL

- Sequences the e-paper panel driver. Queues refresh requests (clear, draw or test, full-screen or clipped) from the host logic, coalesces compatible requests, and controls panel power rails.
- Issues one request at a time to the driver through its start/ready handshake, holding mode and clip fields stable for the whole update.
- Sits between host/framebuffer control and the panel driver. Sole owner of the driver's start, mode and clip inputs.

---
 rtl/eink_update_scheduler.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eink_update_scheduler.sv
// E-paper refresh scheduler: queues and coalesces host refresh requests, sequences
// panel rail power and issues one update at a time to the panel driver.
module eink_update_scheduler #(
    parameter int FIFO_DEPTH      = 4,
    parameter int PWR_UP_CYCLES   = 1000,
    parameter int PWR_IDLE_CYCLES = 50000,
    parameter int START_TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_mode,
    input  logic                        req_clip,
    input  logic [7:0]                  req_x1,
    input  logic [7:0]                  req_x2,
    input  logic [9:0]                  req_y1,
    input  logic [9:0]                  req_y2,
    output logic                        drv_start,
    input  logic                        drv_ready,
    output logic [1:0]                  drv_mode,
    output logic                        drv_clip,
    output logic [7:0]                  drv_x1,
    output logic [7:0]                  drv_x2,
    output logic [9:0]                  drv_y1,
    output logic [9:0]                  drv_y2,
    output logic                        pwr_en,
    input  logic                        pwr_good,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic                        err_timeout,
    output logic                        err_power
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int MAX_UI = (PWR_UP_CYCLES > START_TIMEOUT) ? PWR_UP_CYCLES : START_TIMEOUT;
    localparam int MAXC   = (PWR_IDLE_CYCLES > MAX_UI) ? PWR_IDLE_CYCLES : MAX_UI;
    localparam int CW_RAW = $clog2(MAXC) + 1;
    localparam int CW     = (CW_RAW < 17) ? 17 : CW_RAW;
    localparam logic [CW-1:0] UP_LAST   = CW'(PWR_UP_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(PWR_IDLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_V   = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] mode;
        logic       clip;
        logic [7:0] x1;
        logic [7:0] x2;
        logic [9:0] y1;
        logic [9:0] y2;
    } entry_t;

    typedef enum logic [2:0] {S_OFF, S_PWR_UP, S_IDLE, S_ISSUE, S_RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    entry_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    entry_t          r_drv;
    logic            r_drv_start;
    logic            r_pwr_en;
    logic            r_err_timeout;
    logic            r_err_power;
    logic            r_rdy_meta;
    logic            r_rdy_sync;
    logic            r_pg_meta;
    logic            r_pg_sync;

    logic            w_empty;
    logic            w_full;
    logic [AW-1:0]   w_tail_idx;
    entry_t          w_tail;
    entry_t          w_req;
    entry_t          w_merged;
    logic            w_merge_ok;
    logic            w_accept;
    logic            w_push;
    logic            w_merge;
    logic            w_pop;
    logic            w_set_tmo;
    logic            w_set_pwr;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_V);
    assign w_tail_idx = r_wr_ptr - 1'b1;
    assign w_tail     = r_mem[w_tail_idx];

    // Request entry, merge candidate and acceptance decode
    always_comb begin
        w_req.mode    = req_mode;
        w_req.clip    = req_clip;
        w_req.x1      = req_x1;
        w_req.x2      = req_x2;
        w_req.y1      = req_y1;
        w_req.y2      = req_y2;
        w_merged.mode = w_tail.mode;
        w_merged.clip = w_tail.clip & req_clip;
        w_merged.x1   = (req_x1 < w_tail.x1) ? req_x1 : w_tail.x1;
        w_merged.x2   = (req_x2 > w_tail.x2) ? req_x2 : w_tail.x2;
        w_merged.y1   = (req_y1 < w_tail.y1) ? req_y1 : w_tail.y1;
        w_merged.y2   = (req_y2 > w_tail.y2) ? req_y2 : w_tail.y2;
        w_merge_ok    = !w_empty && (w_tail.mode == req_mode) && (req_mode != 2'd2) && !w_pop;
        req_ready     = !w_full || w_merge_ok;
        w_accept      = req_valid && req_ready;
        w_merge       = w_accept && w_merge_ok;
        w_push        = w_accept && !w_merge_ok && (req_mode != 2'd3);
    end

    // Next-state decode; power loss outranks every other exit while powered
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_set_tmo = 1'b0;
        w_set_pwr = 1'b0;
        case (r_state)
            S_OFF: begin
                if (!w_empty) w_next = S_PWR_UP;
                else          w_next = S_OFF;
            end
            S_PWR_UP: begin
                if ((r_cnt >= UP_LAST) && r_pg_sync) w_next = S_IDLE;
                else                                 w_next = S_PWR_UP;
            end
            S_IDLE: begin
                if (!r_pg_sync) begin
                    w_set_pwr = 1'b1;
                    w_next    = S_OFF;
                end else if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end else if (r_cnt >= IDLE_LAST) begin
                    w_next = S_OFF;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!r_pg_sync) begin
                    w_set_pwr = 1'b1;
                    w_next    = S_OFF;
                end else if (!r_rdy_sync) begin
                    w_next = S_RUN;
                end else if (r_cnt >= TMO_LAST) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_RUN: begin
                if (!r_pg_sync) begin
                    w_set_pwr = 1'b1;
                    w_next    = S_OFF;
                end else if (r_rdy_sync) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_OFF;
        endcase
    end

    // State, shared saturating cycle counter, registered driver/power outputs and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_OFF;
            r_cnt         <= '0;
            r_drv_start   <= 1'b0;
            r_pwr_en      <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_power   <= 1'b0;
            r_drv         <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == S_OFF)) r_cnt <= '0;
            else if (r_cnt != '1)                          r_cnt <= r_cnt + 1'b1;
            else                                           r_cnt <= r_cnt;
            r_drv_start   <= (w_next == S_ISSUE);
            r_pwr_en      <= (w_next != S_OFF);
            r_err_timeout <= r_err_timeout | w_set_tmo;
            r_err_power   <= r_err_power | w_set_pwr;
            if (w_pop) r_drv <= r_mem[r_rd_ptr];
            else       r_drv <= r_drv;
        end
    end

    // Request queue storage, pointers and occupancy; a merge rewrites the tail in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_req;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end else if (w_merge) begin
                r_mem[w_tail_idx] <= w_merged;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Two-flop synchronizers; ready idles high, power-good idles low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_meta <= 1'b1;
            r_rdy_sync <= 1'b1;
            r_pg_meta  <= 1'b0;
            r_pg_sync  <= 1'b0;
        end else begin
            r_rdy_meta <= drv_ready;
            r_rdy_sync <= r_rdy_meta;
            r_pg_meta  <= pwr_good;
            r_pg_sync  <= r_pg_meta;
        end
    end

    assign drv_start   = r_drv_start;
    assign drv_mode    = r_drv.mode;
    assign drv_clip    = r_drv.clip;
    assign drv_x1      = r_drv.x1;
    assign drv_x2      = r_drv.x2;
    assign drv_y1      = r_drv.y1;
    assign drv_y2      = r_drv.y2;
    assign pwr_en      = r_pwr_en;
    assign pending     = r_count;
    assign busy        = (r_state != S_OFF) || !w_empty;
    assign err_timeout = r_err_timeout;
    assign err_power   = r_err_power;
endmodule
